// File: rtl/wisc_pkg.sv
// wisc_pkg: shared opcode, condition-code and flag types for the WISC pipeline.
package wisc_pkg;
    typedef enum logic [3:0] {
        ADD = 4'h0, SUB = 4'h1, XOR = 4'h2, RED = 4'h3,
        SLL = 4'h4, SRA = 4'h5, ROR = 4'h6, PADDSB = 4'h7,
        LW = 4'h8, SW = 4'h9, LLB = 4'hA, LHB = 4'hB,
        B = 4'hC, BR = 4'hD, PCS = 4'hE, HLT = 4'hF
    } opcode_t;
    typedef enum logic [2:0] {
        NE = 3'b000, EQ = 3'b001, GT = 3'b010, LT = 3'b011,
        GTE = 3'b100, LTE = 3'b101, OVFL = 3'b110, UNCOND = 3'b111
    } ccc_t;
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;
    // Opcodes that write Z (ADD/SUB also write V and N).
    function automatic logic is_zflag_op(opcode_t op);
        return op inside {ADD, SUB, XOR, SLL, SRA, ROR};
    endfunction
    function automatic logic is_allflag_op(opcode_t op);
        return op inside {ADD, SUB};
    endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: evaluates a branch condition code against a set of Z/V/N flags.
module branch_cond
    import wisc_pkg::*;
(
    input  ccc_t   ccc,
    input  flags_t flags,
    output logic   taken
);
    always_comb begin
        taken = 1'b0;
        case (ccc)
            NE:      taken = ~flags.z;
            EQ:      taken = flags.z;
            GT:      taken = ~flags.z & ~flags.n;
            LT:      taken = flags.n;
            GTE:     taken = flags.z | ~flags.n;
            LTE:     taken = flags.n | flags.z;
            OVFL:    taken = flags.v;
            UNCOND:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX/MEM pipeline register, Z/V/N flag register and branch resolution
// with optional bypass of flags being written this cycle.
module ex_flag_stage
    import wisc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter bit FLAG_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_ovfl,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_is_branch,
    input  logic [2:0]       id_ccc,
    output logic             mem_valid,
    output logic [3:0]       mem_opcode,
    output logic [WIDTH-1:0] mem_result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             br_taken
);
    flags_t nxt;
    flags_t eff;
    logic   fwe;
    logic   zw;
    logic   aw;
    logic   taken;

    always_comb begin
        fwe   = ex_valid & ~stall & ~flush;
        zw    = fwe & is_zflag_op(opcode_t'(ex_opcode));
        aw    = fwe & is_allflag_op(opcode_t'(ex_opcode));
        nxt.z = zw ? (ex_result == '0) : flag_z;
        nxt.v = aw ? ex_ovfl : flag_v;
        nxt.n = aw ? ex_result[WIDTH-1] : flag_n;
    end

    assign eff      = FLAG_BYPASS ? nxt : flags_t'({flag_z, flag_v, flag_n});
    assign br_taken = id_is_branch & taken;

    branch_cond u_cond (
        .ccc   (ccc_t'(id_ccc)),
        .flags (eff),
        .taken (taken)
    );

    // nxt already equals the held flags unless fwe, so a plain load is safe here.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_opcode <= '0;
            mem_result <= '0;
            {flag_z, flag_v, flag_n} <= 3'b000;
        end else if (flush) begin
            mem_valid <= 1'b0;
        end else if (!stall) begin
            mem_valid  <= ex_valid;
            mem_opcode <= ex_opcode;
            mem_result <= ex_result;
            {flag_z, flag_v, flag_n} <= {nxt.z, nxt.v, nxt.n};
        end
    end
endmodule

// File: tb/tb_ex_flag_stage.sv
// tb_ex_flag_stage: directed and randomized checks of ex_flag_stage against a flag/branch model.
module tb_ex_flag_stage;
    logic        clk = 1'b0;
    logic        rst, ex_valid, ex_ovfl, stall, flush, id_is_branch;
    logic [3:0]  ex_opcode, mem_opcode;
    logic [15:0] ex_result, mem_result;
    logic [2:0]  id_ccc;
    logic        mem_valid, flag_z, flag_v, flag_n, br_taken;
    logic        mem_valid0, flag_z0, flag_v0, flag_n0, br_taken0;
    logic [3:0]  mem_opcode0;
    logic [15:0] mem_result0;
    int total = 0;
    int bad = 0;
    logic        m_valid, m_z, m_v, m_n;
    logic [3:0]  m_op;
    logic [15:0] m_res;

    always #5 clk = ~clk;

    ex_flag_stage #(.WIDTH(16), .FLAG_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush), .id_is_branch(id_is_branch), .id_ccc(id_ccc),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .br_taken(br_taken)
    );

    ex_flag_stage #(.WIDTH(16), .FLAG_BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .stall(stall), .flush(flush), .id_is_branch(id_is_branch), .id_ccc(id_ccc),
        .mem_valid(mem_valid0), .mem_opcode(mem_opcode0), .mem_result(mem_result0),
        .flag_z(flag_z0), .flag_v(flag_v0), .flag_n(flag_n0), .br_taken(br_taken0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond(input logic [2:0] cc, input logic z, input logic v, input logic n);
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Drives one cycle of inputs, checks br_taken combinationally, then the registered state.
    task automatic cyc(input logic r, input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ovf, input logic st, input logic fl, input logic br, input logic [2:0] cc);
        logic we, wz, wall, nz, nv, nn;
        rst = r; ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ovf;
        stall = st; flush = fl; id_is_branch = br; id_ccc = cc;
        we   = v && !st && !fl;
        wz   = we && (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6});
        wall = we && (op inside {4'h0, 4'h1});
        nz   = wz ? (res == 16'h0) : m_z;
        nv   = wall ? ovf : m_v;
        nn   = wall ? res[15] : m_n;
        #1;
        chk("br_bypass", br_taken, br && cond(cc, nz, nv, nn));
        chk("br_nobypass", br_taken0, br && cond(cc, m_z, m_v, m_n));
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_op = 0; m_res = 0; m_z = 0; m_v = 0; m_n = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (!st) begin
            m_valid = v; m_op = op; m_res = res; m_z = nz; m_v = nv; m_n = nn;
        end
        #1;
        chk("mem_valid", mem_valid, m_valid);
        if (m_valid || r) begin
            chk("mem_opcode", mem_opcode, m_op);
            chk("mem_result", mem_result, m_res);
        end
        chk("flags", {flag_z, flag_v, flag_n}, {m_z, m_v, m_n});
        chk("flags_nobypass", {flag_z0, flag_v0, flag_n0}, {m_z, m_v, m_n});
    endtask

    initial begin
        m_valid = 0; m_op = 0; m_res = 0; m_z = 0; m_v = 0; m_n = 0;
        rst = 1; ex_valid = 0; ex_opcode = 0; ex_result = 0; ex_ovfl = 0;
        stall = 0; flush = 0; id_is_branch = 0; id_ccc = 0;
        #1;
        repeat (2) cyc(1, $urandom, 4'($urandom), 16'($urandom), $urandom, $urandom, $urandom, 0, 3'($urandom));
        chk("rst_all_zero", {mem_valid, mem_opcode, mem_result, flag_z, flag_v, flag_n}, 0);
        chk("rst_br", br_taken, 0);
        // saturated ADD overflow: Z stays 0, V set
        cyc(0, 1, 4'h0, 16'h7FFF, 1, 0, 0, 0, 0);
        chk("add_sat", {mem_valid, mem_result, flag_z, flag_v, flag_n}, {1'b1, 16'h7FFF, 3'b010});
        cyc(0, 0, 4'h0, 0, 0, 0, 0, 1, 3'd6);
        // SUB to zero with EQ branch in the same cycle
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4'h1, 16'h0, 0, 0, 0, 1, 3'd1);
        // N and V set, then XOR-to-zero sets only Z, LW leaves flags alone
        cyc(0, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 0);
        cyc(0, 1, 4'h2, 16'h0, 0, 0, 0, 0, 0);
        chk("xor_zvn", {flag_z, flag_v, flag_n}, 3'b111);
        cyc(0, 1, 4'h8, 16'h1234, 1, 0, 0, 1, 3'd0);
        chk("lw_hold", {flag_z, flag_v, flag_n}, 3'b111);
        // stall three cycles on a SUB, then release
        repeat (3) cyc(0, 1, 4'h1, 16'h8000, 0, 1, 0, 1, 3'd3);
        chk("stall_hold", {mem_opcode, flag_n}, {4'h8, 1'b1});
        cyc(0, 1, 4'h1, 16'h8000, 0, 0, 0, 1, 3'd1);
        chk("stall_release", {mem_opcode, mem_result, flag_z}, {4'h1, 16'h8000, 1'b0});
        cyc(0, 1, 4'h0, 16'h0, 0, 1, 1, 1, 3'd1);
        chk("flush_stall", {mem_valid, flag_z}, 2'b00);
        // reset mid-stream with Z set
        cyc(0, 1, 4'h2, 16'h0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4'h0, 16'h0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4'h0, 16'hFFFE, 0, 0, 0, 1, 3'd5);
        for (int i = 0; i < 400; i++) begin
            logic r, br;
            logic [15:0] res;
            r   = ($urandom_range(0, 49) == 0);
            br  = r ? 1'b0 : 1'($urandom);
            res = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cyc(r, $urandom_range(0, 3) != 0, 4'($urandom), res, $urandom,
                $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, br, 3'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
